// File: rtl/regfile_pkg.sv
// Shared constants and grant encoding for the register-file write arbiter.
package regfile_pkg;

    localparam int DATA_W   = 16;
    localparam int ADDR_W   = 4;
    localparam int NUM_REGS = 16;  // must equal 2**ADDR_W

    typedef enum logic {
        GNT_ALU  = 1'b0,
        GNT_LOAD = 1'b1
    } grant_e;

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Writeback requests, scoreboard alloc/query and register-file write port.
interface regfile_write_arbiter_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
);

    logic              req0_valid;
    logic [ADDR_W-1:0] req0_reg;
    logic [DATA_W-1:0] req0_data;
    logic              req0_ready;

    logic              req1_valid;
    logic [ADDR_W-1:0] req1_reg;
    logic [DATA_W-1:0] req1_data;
    logic              req1_ready;

    logic              alloc_valid;
    logic [ADDR_W-1:0] alloc_reg;
    logic [ADDR_W-1:0] chk_reg1;
    logic [ADDR_W-1:0] chk_reg2;
    logic              hazard;

    logic              rf_reg_write;
    logic [ADDR_W-1:0] rf_write_reg;
    logic [DATA_W-1:0] rf_write_data;

    // Pipeline side: requesters and decode.
    modport master (
        output req0_valid, req0_reg, req0_data,
        input  req0_ready,
        output req1_valid, req1_reg, req1_data,
        input  req1_ready,
        output alloc_valid, alloc_reg, chk_reg1, chk_reg2,
        input  hazard,
        input  rf_reg_write, rf_write_reg, rf_write_data
    );

    // Arbiter side.
    modport slave (
        input  req0_valid, req0_reg, req0_data,
        output req0_ready,
        input  req1_valid, req1_reg, req1_data,
        output req1_ready,
        input  alloc_valid, alloc_reg, chk_reg1, chk_reg2,
        output hazard,
        output rf_reg_write, rf_write_reg, rf_write_data
    );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter; on contention the requester not granted last wins.
module rr_arbiter2
    import regfile_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_valid,
    output logic       grant_valid,
    output grant_e     grant_idx
);

    grant_e last_grant_q;
    grant_e last_grant_d;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        grant_valid  = |req_valid;
        grant_idx    = GNT_ALU;
        last_grant_d = last_grant_q;
        if (req_valid == 2'b11) begin
            grant_idx = (last_grant_q == GNT_ALU) ? GNT_LOAD : GNT_ALU;
        end else if (req_valid[1]) begin
            grant_idx = GNT_LOAD;
        end
        if (grant_valid) begin
            last_grant_d = grant_idx;
        end
    end

    // Resets to LOAD so the ALU wins the first contention.
    // NOTE: sequential state uses non-blocking assignments only; blocking here would race other flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= GNT_LOAD;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port between ALU and load writeback,
// with a registered output stage and a pending-write scoreboard.
module regfile_write_arbiter #(
    parameter int DATA_W   = regfile_pkg::DATA_W,
    parameter int ADDR_W   = regfile_pkg::ADDR_W,
    parameter int NUM_REGS = regfile_pkg::NUM_REGS
) (
    input  logic                    clk,
    input  logic                    rst_n,
    regfile_write_arbiter_if.slave  bus
);

    import regfile_pkg::*;

    logic [1:0]        req_valid;
    logic              grant_valid;
    grant_e            grant_idx;
    logic [ADDR_W-1:0] gnt_reg;
    logic [DATA_W-1:0] gnt_data;

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;
    logic                rf_reg_write_q;
    logic                rf_reg_write_d;
    logic [ADDR_W-1:0]   rf_write_reg_q;
    logic [ADDR_W-1:0]   rf_write_reg_d;
    logic [DATA_W-1:0]   rf_write_data_q;
    logic [DATA_W-1:0]   rf_write_data_d;

    // Masking with rst_n keeps both readies low while reset is held.
    assign req_valid = {bus.req1_valid, bus.req0_valid} & {2{rst_n}};

    rr_arbiter2 u_arb (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    assign gnt_reg  = (grant_idx == GNT_LOAD) ? bus.req1_reg  : bus.req0_reg;
    assign gnt_data = (grant_idx == GNT_LOAD) ? bus.req1_data : bus.req0_data;

    assign bus.req0_ready = grant_valid && (grant_idx == GNT_ALU);
    assign bus.req1_ready = grant_valid && (grant_idx == GNT_LOAD);

    // No bypass of a same-cycle clear: the write lands in the file one edge after busy drops.
    assign bus.hazard = busy_q[bus.chk_reg1] | busy_q[bus.chk_reg2];

    always_comb begin
        rf_reg_write_d  = grant_valid;
        rf_write_reg_d  = rf_write_reg_q;
        rf_write_data_d = rf_write_data_q;
        busy_d          = busy_q;
        if (grant_valid) begin
            rf_write_reg_d  = gnt_reg;
            rf_write_data_d = gnt_data;
            busy_d[gnt_reg] = 1'b0;
        end
        // Applied after the clear so a newer allocation of the same register survives.
        if (bus.alloc_valid) begin
            busy_d[bus.alloc_reg] = 1'b1;
        end
    end

    // NOTE: busy is a flop vector, not a RAM, so it is reset; dropping pending state on reset is intended.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q          <= '0;
            rf_reg_write_q  <= 1'b0;
            rf_write_reg_q  <= '0;
            rf_write_data_q <= '0;
        end else begin
            busy_q          <= busy_d;
            rf_reg_write_q  <= rf_reg_write_d;
            rf_write_reg_q  <= rf_write_reg_d;
            rf_write_data_q <= rf_write_data_d;
        end
    end

    assign bus.rf_reg_write  = rf_reg_write_q;
    assign bus.rf_write_reg  = rf_write_reg_q;
    assign bus.rf_write_data = rf_write_data_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: reset, single request, contention,
// hazard tracking, set/clear collision and reset during operation.
module tb_regfile_write_arbiter;

    logic clk;
    logic rst_n;
    int   tests_run;
    int   tests_failed;

    regfile_write_arbiter_if #(.DATA_W(16), .ADDR_W(4)) bus ();

    regfile_write_arbiter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_inputs();
        bus.req0_valid  = 1'b0;
        bus.req0_reg    = '0;
        bus.req0_data   = '0;
        bus.req1_valid  = 1'b0;
        bus.req1_reg    = '0;
        bus.req1_data   = '0;
        bus.alloc_valid = 1'b0;
        bus.alloc_reg   = '0;
        bus.chk_reg1    = '0;
        bus.chk_reg2    = '0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        clear_inputs();
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        next_cycle();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_inputs();
        bus.req0_valid  = 1'b1;
        bus.req1_valid  = 1'b1;
        bus.alloc_valid = 1'b1;
        bus.alloc_reg   = 4'd3;
        bus.chk_reg1    = 4'd3;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests_run++; if (bus.rf_reg_write !== 1'b0) begin tests_failed++; $display("FAIL reset_we: got %b want 0", bus.rf_reg_write); end
        tests_run++; if (bus.rf_write_reg !== 4'd0) begin tests_failed++; $display("FAIL reset_reg: got %0d want 0", bus.rf_write_reg); end
        tests_run++; if (bus.rf_write_data !== 16'h0000) begin tests_failed++; $display("FAIL reset_data: got %h want 0000", bus.rf_write_data); end
        tests_run++; if (bus.hazard !== 1'b0) begin tests_failed++; $display("FAIL reset_hazard: got %b want 0", bus.hazard); end
        tests_run++; if (bus.req0_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_ready0: got %b want 0", bus.req0_ready); end
        tests_run++; if (bus.req1_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_ready1: got %b want 0", bus.req1_ready); end
        clear_inputs();
        bus.chk_reg1 = 4'd3;
        rst_n = 1'b1;
        next_cycle();
        next_cycle();
        @(negedge clk);
        tests_run++; if (bus.rf_reg_write !== 1'b0) begin tests_failed++; $display("FAIL idle_we: got %b want 0", bus.rf_reg_write); end
        tests_run++; if (bus.hazard !== 1'b0) begin tests_failed++; $display("FAIL idle_hazard: got %b want 0", bus.hazard); end
        tests_run++; if (bus.rf_write_reg !== 4'd0) begin tests_failed++; $display("FAIL idle_reg: got %0d want 0", bus.rf_write_reg); end
        next_cycle();
    endtask

    task automatic test_alu_only();
        bus.req0_valid = 1'b1;
        bus.req0_reg   = 4'd3;
        bus.req0_data  = 16'h1234;
        @(negedge clk);
        tests_run++; if (bus.req0_ready !== 1'b1) begin tests_failed++; $display("FAIL alu_ready0: got %b want 1", bus.req0_ready); end
        tests_run++; if (bus.req1_ready !== 1'b0) begin tests_failed++; $display("FAIL alu_ready1: got %b want 0", bus.req1_ready); end
        tests_run++; if (bus.rf_reg_write !== 1'b0) begin tests_failed++; $display("FAIL alu_we_early: got %b want 0", bus.rf_reg_write); end
        next_cycle();
        bus.req0_valid = 1'b0;
        @(negedge clk);
        tests_run++; if (bus.rf_reg_write !== 1'b1) begin tests_failed++; $display("FAIL alu_we: got %b want 1", bus.rf_reg_write); end
        tests_run++; if (bus.rf_write_reg !== 4'd3) begin tests_failed++; $display("FAIL alu_reg: got %0d want 3", bus.rf_write_reg); end
        tests_run++; if (bus.rf_write_data !== 16'h1234) begin tests_failed++; $display("FAIL alu_data: got %h want 1234", bus.rf_write_data); end
        next_cycle();
        @(negedge clk);
        tests_run++; if (bus.rf_reg_write !== 1'b0) begin tests_failed++; $display("FAIL alu_we_drop: got %b want 0", bus.rf_reg_write); end
        tests_run++; if (bus.rf_write_reg !== 4'd3) begin tests_failed++; $display("FAIL alu_reg_hold: got %0d want 3", bus.rf_write_reg); end
        tests_run++; if (bus.rf_write_data !== 16'h1234) begin tests_failed++; $display("FAIL alu_data_hold: got %h want 1234", bus.rf_write_data); end
        next_cycle();
    endtask

    task automatic test_contention();
        logic [3:0]  exp_reg [4];
        logic [15:0] exp_data [4];
        exp_reg  = '{4'd1, 4'd2, 4'd1, 4'd2};
        exp_data = '{16'hAAAA, 16'hBBBB, 16'hAAAA, 16'hBBBB};
        apply_reset();
        bus.req0_valid = 1'b1;
        bus.req0_reg   = 4'd1;
        bus.req0_data  = 16'hAAAA;
        bus.req1_valid = 1'b1;
        bus.req1_reg   = 4'd2;
        bus.req1_data  = 16'hBBBB;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            tests_run++; if (bus.req0_ready !== (i % 2 == 0)) begin tests_failed++; $display("FAIL cont_ready0[%0d]: got %b want %b", i, bus.req0_ready, (i % 2 == 0)); end
            tests_run++; if (bus.req1_ready !== (i % 2 == 1)) begin tests_failed++; $display("FAIL cont_ready1[%0d]: got %b want %b", i, bus.req1_ready, (i % 2 == 1)); end
            if (i > 0) begin
                tests_run++; if (bus.rf_reg_write !== 1'b1) begin tests_failed++; $display("FAIL cont_we[%0d]: got %b want 1", i - 1, bus.rf_reg_write); end
                tests_run++; if (bus.rf_write_reg !== exp_reg[i-1]) begin tests_failed++; $display("FAIL cont_reg[%0d]: got %0d want %0d", i - 1, bus.rf_write_reg, exp_reg[i-1]); end
                tests_run++; if (bus.rf_write_data !== exp_data[i-1]) begin tests_failed++; $display("FAIL cont_data[%0d]: got %h want %h", i - 1, bus.rf_write_data, exp_data[i-1]); end
            end
            next_cycle();
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        @(negedge clk);
        tests_run++; if (bus.rf_write_reg !== exp_reg[3]) begin tests_failed++; $display("FAIL cont_reg[3]: got %0d want %0d", bus.rf_write_reg, exp_reg[3]); end
        tests_run++; if (bus.rf_write_data !== exp_data[3]) begin tests_failed++; $display("FAIL cont_data[3]: got %h want %h", bus.rf_write_data, exp_data[3]); end
        next_cycle();
    endtask

    task automatic test_hazard();
        bus.alloc_valid = 1'b1;
        bus.alloc_reg   = 4'd5;
        bus.chk_reg1    = 4'd5;
        bus.chk_reg2    = 4'd0;
        @(negedge clk);
        tests_run++; if (bus.hazard !== 1'b0) begin tests_failed++; $display("FAIL haz_before_alloc: got %b want 0", bus.hazard); end
        next_cycle();
        bus.alloc_valid = 1'b0;
        @(negedge clk);
        tests_run++; if (bus.hazard !== 1'b1) begin tests_failed++; $display("FAIL haz_set: got %b want 1", bus.hazard); end
        next_cycle();
        bus.req1_valid = 1'b1;
        bus.req1_reg   = 4'd5;
        bus.req1_data  = 16'h5555;
        @(negedge clk);
        tests_run++; if (bus.hazard !== 1'b1) begin tests_failed++; $display("FAIL haz_no_bypass: got %b want 1", bus.hazard); end
        tests_run++; if (bus.req1_ready !== 1'b1) begin tests_failed++; $display("FAIL haz_ready1: got %b want 1", bus.req1_ready); end
        next_cycle();
        bus.req1_valid = 1'b0;
        @(negedge clk);
        tests_run++; if (bus.hazard !== 1'b0) begin tests_failed++; $display("FAIL haz_clear: got %b want 0", bus.hazard); end
        tests_run++; if (bus.rf_write_reg !== 4'd5) begin tests_failed++; $display("FAIL haz_wb_reg: got %0d want 5", bus.rf_write_reg); end
        tests_run++; if (bus.rf_write_data !== 16'h5555) begin tests_failed++; $display("FAIL haz_wb_data: got %h want 5555", bus.rf_write_data); end
        next_cycle();
    endtask

    task automatic test_collision();
        bus.chk_reg1    = 4'd0;
        bus.chk_reg2    = 4'd0;
        bus.alloc_valid = 1'b1;
        bus.alloc_reg   = 4'd7;
        next_cycle();
        bus.alloc_reg   = 4'd8;
        next_cycle();
        bus.alloc_reg   = 4'd7;
        bus.req0_valid  = 1'b1;
        bus.req0_reg    = 4'd7;
        bus.req0_data   = 16'h7777;
        bus.chk_reg2    = 4'd7;
        @(negedge clk);
        tests_run++; if (bus.req0_ready !== 1'b1) begin tests_failed++; $display("FAIL coll_ready0: got %b want 1", bus.req0_ready); end
        tests_run++; if (bus.hazard !== 1'b1) begin tests_failed++; $display("FAIL coll_hazard_pre: got %b want 1", bus.hazard); end
        next_cycle();
        bus.alloc_reg   = 4'd9;
        bus.req0_reg    = 4'd8;
        bus.req0_data   = 16'h8888;
        @(negedge clk);
        tests_run++; if (bus.hazard !== 1'b1) begin tests_failed++; $display("FAIL coll_set_wins: got %b want 1", bus.hazard); end
        tests_run++; if (bus.rf_write_reg !== 4'd7) begin tests_failed++; $display("FAIL coll_wb_reg: got %0d want 7", bus.rf_write_reg); end
        tests_run++; if (bus.rf_reg_write !== 1'b1) begin tests_failed++; $display("FAIL coll_wb_we: got %b want 1", bus.rf_reg_write); end
        next_cycle();
        clear_inputs();
        bus.chk_reg1 = 4'd8;
        bus.chk_reg2 = 4'd0;
        @(negedge clk);
        tests_run++; if (bus.hazard !== 1'b0) begin tests_failed++; $display("FAIL diff_clear8: got %b want 0", bus.hazard); end
        tests_run++; if (bus.rf_write_reg !== 4'd8) begin tests_failed++; $display("FAIL diff_wb_reg: got %0d want 8", bus.rf_write_reg); end
        bus.chk_reg1 = 4'd9;
        #1;
        tests_run++; if (bus.hazard !== 1'b1) begin tests_failed++; $display("FAIL diff_set9: got %b want 1", bus.hazard); end
        next_cycle();
    endtask

    task automatic test_reset_midop();
        clear_inputs();
        bus.req0_valid  = 1'b1;
        bus.req0_reg    = 4'd4;
        bus.req0_data   = 16'h4444;
        bus.alloc_valid = 1'b1;
        bus.alloc_reg   = 4'd10;
        bus.chk_reg1    = 4'd10;
        bus.chk_reg2    = 4'd7;
        next_cycle();
        bus.req0_valid  = 1'b0;
        bus.alloc_valid = 1'b0;
        tests_run++; if (bus.rf_reg_write !== 1'b1) begin tests_failed++; $display("FAIL midop_we_pre: got %b want 1", bus.rf_reg_write); end
        tests_run++; if (bus.hazard !== 1'b1) begin tests_failed++; $display("FAIL midop_hazard_pre: got %b want 1", bus.hazard); end
        #1;
        rst_n = 1'b0;
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        bus.req1_reg   = 4'd6;
        #1;
        tests_run++; if (bus.rf_reg_write !== 1'b0) begin tests_failed++; $display("FAIL midop_we_async: got %b want 0", bus.rf_reg_write); end
        tests_run++; if (bus.rf_write_reg !== 4'd0) begin tests_failed++; $display("FAIL midop_reg_async: got %0d want 0", bus.rf_write_reg); end
        tests_run++; if (bus.hazard !== 1'b0) begin tests_failed++; $display("FAIL midop_busy_clear: got %b want 0", bus.hazard); end
        tests_run++; if (bus.req0_ready !== 1'b0) begin tests_failed++; $display("FAIL midop_ready0_rst: got %b want 0", bus.req0_ready); end
        tests_run++; if (bus.req1_ready !== 1'b0) begin tests_failed++; $display("FAIL midop_ready1_rst: got %b want 0", bus.req1_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        tests_run++; if (bus.req0_ready !== 1'b1) begin tests_failed++; $display("FAIL midop_rr_ready0: got %b want 1", bus.req0_ready); end
        tests_run++; if (bus.req1_ready !== 1'b0) begin tests_failed++; $display("FAIL midop_rr_ready1: got %b want 0", bus.req1_ready); end
        next_cycle();
        clear_inputs();
        @(negedge clk);
        tests_run++; if (bus.rf_write_reg !== 4'd4) begin tests_failed++; $display("FAIL midop_post_reg: got %0d want 4", bus.rf_write_reg); end
        tests_run++; if (bus.rf_write_data !== 16'h4444) begin tests_failed++; $display("FAIL midop_post_data: got %h want 4444", bus.rf_write_data); end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_alu_only();
        test_contention();
        test_hazard();
        test_collision();
        test_reset_midop();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the register file's single write port between two writeback requesters: req0 is the ALU writeback and req1 is the load-data writeback.
- Requests are arbitrated round-robin and issued through a registered output stage that drives the register file's reg_write, write_reg and write_data.
- A 16-entry pending-write scoreboard tracks destination registers that have an allocated but uncommitted write.
- The decode stage queries the scoreboard to detect read-after-write hazards.

Parameters:
- DATA_W, 16, register data width.
- ADDR_W, 4, register index width.
- NUM_REGS, 16, number of scoreboard entries; must equal 2**ADDR_W.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req0_valid  input  1  ALU writeback request.
- req0_reg  input  ADDR_W  ALU destination register.
- req0_data  input  DATA_W  ALU result.
- req0_ready  output  1  request 0 accepted this cycle.
- req1_valid  input  1  load writeback request.
- req1_reg  input  ADDR_W  load destination register.
- req1_data  input  DATA_W  load data.
- req1_ready  output  1  request 1 accepted this cycle.
- alloc_valid  input  1  decode has issued an instruction that will write alloc_reg.
- alloc_reg  input  ADDR_W  destination register being allocated.
- chk_reg1  input  ADDR_W  source register 1 under decode.
- chk_reg2  input  ADDR_W  source register 2 under decode.
- hazard  output  1  a source register has a pending write.
- rf_reg_write  output  1  write enable to the register file.
- rf_write_reg  output  ADDR_W  write index to the register file.
- rf_write_data  output  DATA_W  write data to the register file.

Behaviour:
- Reset (async assert, sync release): rf_reg_write=0, rf_write_reg=0, rf_write_data=0, busy[15:0]=0, last_grant=1 (so req0 wins the first contention).
- During reset, req0_ready, req1_ready and hazard are all 0.
- Handshake: a request transfers in the cycle its valid and ready are both high.
  - Ready is combinational from the valids and last_grant.
  - Ready never depends on itself.
  - A requester holds valid, reg and data stable until it is accepted.
- Arbitration, one grant per cycle:
  - Only req0 valid: grant 0.
  - Only req1 valid: grant 1.
  - Both valid: grant the requester not in last_grant.
  - last_grant updates only on a grant.
  - reqN_ready = grant==N.
- Output stage: latency is 1 cycle.
  - On a grant, the next edge registers rf_reg_write=1, rf_write_reg=reg and rf_write_data=data.
  - With no grant, rf_reg_write=0; rf_write_reg and rf_write_data hold their values.
  - The register file commits on the following edge.
- Scoreboard:
  - alloc_valid sets busy[alloc_reg] at the edge.
  - A grant clears busy[granted reg] at the same edge the output register loads. The registered write lands one edge later; decode logic must tolerate this, because the register file is read synchronously.
  - Simultaneous set and clear of the same index: set wins, because a newer producer is outstanding.
  - Set and clear of different indices: both take effect.
- hazard = busy[chk_reg1] | busy[chk_reg2]. It is combinational from the busy register only, with no bypass from the same-cycle clear.
- A grant for a register that is not busy is legal. It writes normally and the scoreboard is unchanged.
- Register 0 is an ordinary register; it has no hardwired zero.
- Reset mid-operation: an in-flight granted write is dropped (rf_reg_write forced to 0), and all pending scoreboard state is lost.

Decomposition:
- Shared package regfile_pkg holds:
  - DATA_W, ADDR_W and NUM_REGS constants.
  - A grant encoding constant: GNT_ALU=0, GNT_LOAD=1.
- One natural sub-module, rr_arbiter2: a 2-way round-robin arbiter with the last_grant register, outputs grant_valid and grant_idx.
- The scoreboard and output stage stay in the top module.

Test Plan:
1. Reset check: hold rst_n=0 and toggle clk. Required: rf_reg_write=0, hazard=0, both readies=0. After release with no requests, outputs hold.
2. ALU only: req0_valid=1, reg=3, data=16'h1234 for 1 cycle. Required: req0_ready=1 that cycle; next cycle rf_reg_write=1, rf_write_reg=3, rf_write_data=16'h1234; the cycle after, rf_reg_write=0.
3. Contention: both valid for 4 cycles, req0 reg=1/data=A and req1 reg=2/data=B, each held until accepted and then re-presented. Required grants 0,1,0,1; output sequence reg 1,2,1,2; neither requester starves.
4. Hazard: alloc reg 5, then chk_reg1=5. Required: hazard=1 until the edge of the req1 grant for reg 5, and hazard=0 in the following cycle.
5. Set/clear collision: reg 7 busy; in the same cycle alloc_reg=7 and req0 is granted for reg 7. Required: busy[7] stays 1 and hazard=1 with chk_reg2=7.
6. Reset mid-op: assert rst_n low while a grant is pending. Required: rf_reg_write drops immediately (async), busy clears, and last_grant resets so req0 wins the next contention.
